// File: rtl/usb_dpdm_tx.sv
// USB D+/D- line driver: maps NRZI bits to J/K symbols and appends the
// SE0/J end-of-packet sequence, with a watchdog that forces EOP on runaway packets.
module usb_dpdm_tx #(
    parameter int unsigned SE0_CYCLES = 2,
    parameter int unsigned J_CYCLES   = 1,
    parameter int unsigned MAX_BITS   = 1024,
    parameter bit          LOW_SPEED  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_in,
    input  logic start_dpdm,
    input  logic eop,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic busy,
    output logic done,
    output logic abort
);

    localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_BITS - 1);
    localparam logic [3:0]       SE0_LAST = 4'(SE0_CYCLES);
    localparam logic [3:0]       J_LAST   = 4'(J_CYCLES);
    localparam logic             J_DP     = !LOW_SPEED;
    localparam logic             J_DM     = LOW_SPEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_SE0,
        S_EOPJ
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_se0_cnt;
    logic [3:0]       r_j_cnt;
    logic             r_dp;
    logic             r_dm;
    logic             r_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_abort;

    // s_in=1 is J; low speed swaps which line is high for J
    logic w_sym_dp;
    assign w_sym_dp = s_in ^ LOW_SPEED;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_se0_cnt <= '0;
            r_j_cnt   <= '0;
            r_dp      <= J_DP;
            r_dm      <= J_DM;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_dpdm) begin
                        r_state   <= S_DATA;
                        r_oe      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_dp      <= w_sym_dp;
                        r_dm      <= ~w_sym_dp;
                        r_bit_cnt <= '0;
                    end else begin
                        r_oe   <= 1'b0;
                        r_busy <= 1'b0;
                        r_dp   <= J_DP;
                        r_dm   <= J_DM;
                    end
                end
                S_DATA: begin
                    // the start cycle already sent one bit, so the watchdog
                    // trips on the MAX_BITS-th DATA clock
                    if (eop || (r_bit_cnt == WD_LAST)) begin
                        r_state   <= S_SE0;
                        r_dp      <= 1'b0;
                        r_dm      <= 1'b0;
                        r_se0_cnt <= 4'd1;
                        r_abort   <= !eop;
                    end else begin
                        r_dp      <= w_sym_dp;
                        r_dm      <= ~w_sym_dp;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_SE0: begin
                    if (r_se0_cnt == SE0_LAST) begin
                        r_state <= S_EOPJ;
                        r_dp    <= J_DP;
                        r_dm    <= J_DM;
                        r_j_cnt <= 4'd1;
                    end else begin
                        r_se0_cnt <= r_se0_cnt + 4'd1;
                    end
                end
                S_EOPJ: begin
                    if (r_j_cnt == J_LAST) begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_j_cnt <= r_j_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dp    = r_dp;
    assign dm    = r_dm;
    assign oe    = r_oe;
    assign busy  = r_busy;
    assign done  = r_done;
    assign abort = r_abort;

endmodule

// File: tb/tb_usb_dpdm_tx.sv
// Directed bench for usb_dpdm_tx: three parameterisations (full speed, low speed
// with long SE0, short watchdog) driven from one vector table plus a timing sequence.
module tb_usb_dpdm_tx;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] start;
    logic [2:0] eop;
    logic [2:0] s_in;
    logic [2:0] dp;
    logic [2:0] dm;
    logic [2:0] oe;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] abort;

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    usb_dpdm_tx #(.SE0_CYCLES(2), .J_CYCLES(1), .MAX_BITS(1024), .LOW_SPEED(1'b0)) u_fs (
        .clk(clk), .rst_n(rst_n[0]), .s_in(s_in[0]), .start_dpdm(start[0]), .eop(eop[0]),
        .dp(dp[0]), .dm(dm[0]), .oe(oe[0]), .busy(busy[0]), .done(done[0]), .abort(abort[0])
    );

    usb_dpdm_tx #(.SE0_CYCLES(3), .J_CYCLES(1), .MAX_BITS(1024), .LOW_SPEED(1'b1)) u_ls (
        .clk(clk), .rst_n(rst_n[1]), .s_in(s_in[1]), .start_dpdm(start[1]), .eop(eop[1]),
        .dp(dp[1]), .dm(dm[1]), .oe(oe[1]), .busy(busy[1]), .done(done[1]), .abort(abort[1])
    );

    usb_dpdm_tx #(.SE0_CYCLES(2), .J_CYCLES(1), .MAX_BITS(8), .LOW_SPEED(1'b0)) u_wd (
        .clk(clk), .rst_n(rst_n[2]), .s_in(s_in[2]), .start_dpdm(start[2]), .eop(eop[2]),
        .dp(dp[2]), .dm(dm[2]), .oe(oe[2]), .busy(busy[2]), .done(done[2]), .abort(abort[2])
    );

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                assert (!(dp[i] && dm[i]))
                    else $error("FAIL se1_line dut%0d dp=1 dm=1, required never both high", i);
            end
        end
    end

    // expected word order: {oe, dp, dm, busy, done, abort}
    typedef struct {
        int         d;
        logic       rst;
        logic       st;
        logic       e;
        logic       s;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int d, logic r, logic st, logic e, logic s,
                                logic [5:0] x, string n);
        vecs.push_back('{d, r, st, e, s, x, n});
    endfunction

    // unselected instances are held in reset so each section starts clean
    task automatic drive(int d, logic r, logic st, logic e, logic s);
        rst_n = '0;
        start = '0;
        eop   = '0;
        s_in  = '0;
        rst_n[d] = r;
        start[d] = st;
        eop[d]   = e;
        s_in[d]  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string n, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s got %0d required %0d", n, act, req);
    endtask

    task automatic apply(vec_t v);
        logic [5:0] act;
        drive(v.d, v.rst, v.st, v.e, v.s);
        act = {oe[v.d], dp[v.d], dm[v.d], busy[v.d], done[v.d], abort[v.d]};
        n_checks++;
        if (act === v.exp) n_pass++;
        else $display("FAIL %s dut%0d got oe,dp,dm,busy,done,abort=%b required %b",
                      v.name, v.d, act, v.exp);
    endtask

    initial begin
        logic [3:0] pat;
        int         oe_cnt;
        int         done_cnt;
        int         abort_cnt;
        bit         seen;

        rst_n = '0;
        start = '0;
        eop   = '0;
        s_in  = '0;

        // full speed: reset, idle, stray eop, packet 1,0,0,1
        add(0, 0, 0, 0, 0, 6'b010000, "fs_rst0");
        add(0, 0, 0, 0, 0, 6'b010000, "fs_rst1");
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 6'b010000, "fs_idle");
        add(0, 1, 0, 1, 1, 6'b010000, "fs_eop_in_idle");
        add(0, 1, 1, 0, 1, 6'b110100, "fs_b1");
        add(0, 1, 0, 0, 0, 6'b101100, "fs_b2");
        add(0, 1, 0, 0, 0, 6'b101100, "fs_b3");
        add(0, 1, 0, 0, 1, 6'b110100, "fs_b4");
        add(0, 1, 0, 1, 1, 6'b100100, "fs_se0_a");
        add(0, 1, 1, 0, 0, 6'b100100, "fs_se0_b_start_ign");
        add(0, 1, 0, 0, 0, 6'b110100, "fs_eopj");
        add(0, 1, 0, 0, 0, 6'b010010, "fs_done");
        // start in the done cycle, then eop+start together in DATA
        add(0, 1, 1, 0, 0, 6'b101100, "b2b_b1");
        add(0, 1, 0, 0, 1, 6'b110100, "b2b_b2");
        add(0, 1, 1, 1, 0, 6'b100100, "b2b_se0_a");
        add(0, 1, 0, 0, 0, 6'b100100, "b2b_se0_b");
        add(0, 1, 0, 0, 0, 6'b110100, "b2b_eopj");
        add(0, 1, 0, 0, 0, 6'b010010, "b2b_done");
        add(0, 1, 0, 0, 0, 6'b010000, "b2b_idle");
        // reset on the third data bit, then a clean packet
        add(0, 1, 1, 0, 1, 6'b110100, "mr_b1");
        add(0, 1, 0, 0, 0, 6'b101100, "mr_b2");
        add(0, 0, 0, 0, 1, 6'b010000, "mr_reset");
        add(0, 1, 0, 0, 0, 6'b010000, "mr_idle_a");
        add(0, 1, 0, 0, 0, 6'b010000, "mr_idle_b");
        add(0, 1, 1, 0, 0, 6'b101100, "mr_new_b1");
        add(0, 1, 0, 1, 0, 6'b100100, "mr_se0_a");
        add(0, 1, 0, 0, 0, 6'b100100, "mr_se0_b");
        add(0, 1, 0, 0, 0, 6'b110100, "mr_eopj");
        add(0, 1, 0, 0, 0, 6'b010010, "mr_done");

        // low speed, three SE0 clocks
        add(1, 0, 0, 0, 0, 6'b001000, "ls_rst0");
        add(1, 0, 0, 0, 0, 6'b001000, "ls_rst1");
        add(1, 1, 0, 0, 0, 6'b001000, "ls_idle");
        add(1, 1, 1, 0, 1, 6'b101100, "ls_b1");
        add(1, 1, 0, 0, 0, 6'b110100, "ls_b2");
        add(1, 1, 0, 0, 0, 6'b110100, "ls_b3");
        add(1, 1, 0, 0, 1, 6'b101100, "ls_b4");
        add(1, 1, 0, 1, 0, 6'b100100, "ls_se0_a");
        add(1, 1, 0, 0, 0, 6'b100100, "ls_se0_b");
        add(1, 1, 0, 0, 0, 6'b100100, "ls_se0_c");
        add(1, 1, 0, 0, 0, 6'b101100, "ls_eopj");
        add(1, 1, 0, 0, 0, 6'b001010, "ls_done");
        add(1, 1, 0, 0, 0, 6'b001000, "ls_idle_after");

        // watchdog at 8 bits: 20 bits offered, eop pulsed while already in EOP
        add(2, 0, 0, 0, 0, 6'b010000, "wd_rst0");
        add(2, 0, 0, 0, 0, 6'b010000, "wd_rst1");
        for (int k = 1; k <= 20; k++) begin
            logic       s;
            logic [5:0] x;
            s = k[0];
            if (k <= 8)       x = {1'b1, s, ~s, 1'b1, 1'b0, 1'b0};
            else if (k == 9)  x = 6'b100101;
            else if (k == 10) x = 6'b100100;
            else if (k == 11) x = 6'b110100;
            else if (k == 12) x = 6'b010010;
            else              x = 6'b010000;
            add(2, 1, k == 1, (k == 10) || (k == 11), s, x, $sformatf("wd_k%0d", k));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i == 1) armed = 1'b1;
        end

        // oe-high time and single done pulse for a 4-bit packet, bounded wait
        pat       = 4'b1001;
        oe_cnt    = 0;
        done_cnt  = 0;
        abort_cnt = 0;
        seen      = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i == 0, 0, pat[3-i]);
            oe_cnt += int'(oe[0]);
        end
        drive(0, 1, 0, 1, 0);
        oe_cnt += int'(oe[0]);
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(0, 1, 0, 0, 0);
            oe_cnt    += int'(oe[0]);
            done_cnt  += int'(done[0]);
            abort_cnt += int'(abort[0]);
            if (done[0]) seen = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 0, 0);
            oe_cnt   += int'(oe[0]);
            done_cnt += int'(done[0]);
        end
        check("seq_done_seen", int'(seen), 1);
        check("seq_oe_clocks", oe_cnt, 7);
        check("seq_done_pulses", done_cnt, 1);
        check("seq_no_abort", abort_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_dpdm_tx.md
Name: usb_dpdm_tx

Overview:
- Final stage of the USB transmit chain (crc -> bit_stuff -> nrzi -> this block).
- Consumes the NRZI-encoded serial bit stream one bit per clock and drives the differential bus pair dp/dm with J/K symbols.
- On request from nrzi, generates the end-of-packet sequence: SE0 for SE0_CYCLES, then J for J_CYCLES. Then releases the bus and pulses done.
- Includes a runaway-packet watchdog that forces EOP if nrzi never requests one.

Parameters:
- SE0_CYCLES, 2: clocks of SE0 (dp=0, dm=0) in EOP; legal range 1..15.
- J_CYCLES, 1: clocks of driven J after SE0 before release; legal range 1..15.
- MAX_BITS, 1024: maximum DATA-state clocks before the watchdog forces EOP; legal range 2..65535.
- LOW_SPEED, 0: 0 = full speed (J: dp=1, dm=0); 1 = low speed (J: dp=0, dm=1). K is always the inverse of J.

Ports:
- clk  in  1  system clock, one bit time per cycle.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- s_in  in  1  NRZI bit from nrzi; 1 -> J, 0 -> K. Valid only in DATA cycles without eop.
- start_dpdm  in  1  one-cycle pulse from nrzi; s_in in the same cycle is the first bit.
- eop  in  1  one-cycle pulse from nrzi in the cycle after the last data bit; s_in is ignored that cycle.
- dp  out  1  D+ line value (registered).
- dm  out  1  D- line value (registered).
- oe  out  1  transceiver output enable (registered); 1 = block drives the bus.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle pulse when the bus is released.
- abort  out  1  one-cycle pulse, coincident with entry to SE0, when the watchdog fires.

Behaviour:
- Clock, reset and outputs:
  - One clock; reset is synchronous and active-low (rst_n sampled at posedge clk).
  - Reset values: state=IDLE, oe=0, dp/dm = idle J (1/0 full speed, 0/1 low speed), busy=0, done=0, abort=0, counters=0.
  - All outputs are registered. A bus value decided from inputs at edge N appears after edge N.
- IDLE:
  - oe=0; dp/dm hold idle J.
  - start_dpdm=1 -> next state DATA; after the edge: oe=1 and dp/dm = symbol(s_in).
  - eop alone in IDLE is ignored.
  - start_dpdm and eop together in IDLE: start is taken, eop is ignored.
- DATA:
  - Each cycle with eop=0: dp/dm <= symbol(s_in); bit counter increments.
  - eop=1 -> next state SE0; dp=0, dm=0; SE0 counter loads 1.
  - start_dpdm in DATA is ignored, even when it coincides with eop.
  - Watchdog: if the bit counter reaches MAX_BITS with eop=0, go to SE0 exactly as for eop and pulse abort for one cycle.
- SE0:
  - Holds dp=dm=0 for exactly SE0_CYCLES clocks.
  - Then goes to EOPJ with dp/dm = J.
  - All inputs are ignored.
- EOPJ:
  - Holds J with oe=1 for exactly J_CYCLES clocks.
  - Then goes to IDLE: oe=0, dp/dm stay at J, done=1 for that single cycle.
- A start_dpdm that arrives in the IDLE cycle in which done is high is accepted, giving back-to-back packets.
- Reset mid-packet: at the reset edge, all outputs go to their reset values (bus released, no EOP emitted), and done/abort are not pulsed.
- Line state is never dp=dm=1 (SE1). An assertion in the bench checks this.
- Packet timing: total oe-high time = (data bits) + SE0_CYCLES + J_CYCLES clocks.
- Bit counter width: clog2(MAX_BITS+1). It clears on entry to DATA and does not wrap.

Test Plan:
- Reset then idle: rst_n=0 for 2 clocks, then 1 for 5 clocks with no stimulus -> oe=0, dp=1, dm=0, busy=0, done=0 throughout.
- Basic packet (full speed): start_dpdm with s_in bits 1,0,0,1 then eop -> after each edge dp/dm = 10,01,01,10, then 00,00, then 10 with oe=1; next cycle oe=0 and done=1 for one cycle; oe high for 7 clocks total.
- LOW_SPEED=1, SE0_CYCLES=3, same stimulus -> dp/dm = 01,10,10,01, then 00 x3, then 01; done pulses once.
- Watchdog: MAX_BITS=8, start then 20 bits with no eop -> exactly 8 data symbols, abort=1 on the SE0 entry cycle, EOP completes, done=1; later eop/s_in are ignored until IDLE.
- Mid-packet reset: rst_n=0 on the third data bit -> after that edge oe=0, dp/dm=10, busy=0, no done pulse. A new start after reset transmits normally.
- Back-to-back and corner inputs:
  - start_dpdm in the done cycle -> a second packet begins with no idle gap.
  - eop in IDLE -> no effect.
  - start_dpdm during SE0 -> ignored.
  - dp=dm=1 is never observed.
